// File: rtl/dsram_bridge.sv
// rtl/dsram_bridge.sv - data-SRAM responder bridging single-cycle pipeline accesses onto a gnt/response memory port
// One transaction outstanding at most; the pipeline is held through stallreq_mem until DONE.
module dsram_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_mem,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_bvalid,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      r_state;
  state_t      w_next;
  logic [29:0] r_addr;
  logic [3:0]  r_wen;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [15:0] r_cnt;
  logic        r_err;

  logic w_is_wr;
  logic w_resp;
  logic w_capture;
  logic w_tmo;
  logic w_cnt_clr;
  logic w_cnt_inc;

  // Only the response type matching the latched access counts; the other valid is ignored.
  assign w_is_wr = |r_wen;
  assign w_resp  = w_is_wr ? mem_bvalid : mem_rvalid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    stallreq_mem = 1'b0;
    mem_req      = 1'b0;
    w_capture    = 1'b0;
    w_tmo        = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        stallreq_mem = data_sram_en & resetn;
        if (data_sram_en) begin
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        mem_req      = 1'b1;
        stallreq_mem = 1'b1;
        if (mem_gnt) begin
          if (w_resp) begin
            w_next    = S_DONE;
            w_capture = ~w_is_wr;
          end else begin
            w_next    = S_WAIT;
            w_cnt_clr = 1'b1;
          end
        end
      end
      S_WAIT: begin
        stallreq_mem = 1'b1;
        w_cnt_inc    = 1'b1;
        if (w_resp) begin
          w_next    = S_DONE;
          w_capture = ~w_is_wr;
        end else if (r_cnt == TMO_LAST) begin
          w_next = S_DONE;
          w_tmo  = 1'b1;
        end
      end
      // DONE releases the stall for one cycle; the en still seen here belongs to the finished access.
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr  <= '0;
      r_wen   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_tmo;
      if (r_state == S_IDLE && data_sram_en) begin
        r_addr  <= data_sram_addr[31:2];
        r_wen   <= data_sram_wen;
        r_wdata <= data_sram_wdata;
      end
      if (w_capture) begin
        r_rdata <= mem_rdata;
      end else if (w_tmo && !w_is_wr) begin
        r_rdata <= ERR_DATA;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign mem_wr          = mem_req & w_is_wr;
  assign mem_wstrb       = r_wen;
  assign mem_addr        = {r_addr, 2'b00};
  assign mem_wdata       = r_wdata;
  assign data_sram_rdata = r_rdata;
  assign mem_err         = r_err;

endmodule

// File: tb/tb_dsram_bridge.sv
// tb/tb_dsram_bridge.sv - scoreboard bench for dsram_bridge
module tb_dsram_bridge;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq_mem;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_bvalid;
  logic        mem_err;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  dsram_bridge #(.TIMEOUT_CYC(TMO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .resetn(resetn),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .stallreq_mem(stallreq_mem),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_bvalid(mem_bvalid),
    .mem_err(mem_err)
  );

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if (data_sram_rdata !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata got=%h want=00000000", data_sram_rdata);
    end
    n_chk++;
    if (stallreq_mem !== 1'b0 || mem_req !== 1'b0 || mem_wr !== 1'b0 || mem_err !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl got stall=%b req=%b wr=%b err=%b want all 0", stallreq_mem, mem_req, mem_wr, mem_err);
    end
    n_chk++;
    if (mem_addr !== 32'h0 || mem_wstrb !== 4'h0 || mem_wdata !== 32'h0) begin
      n_err++; $display("FAIL reset_latches got addr=%h strb=%h wdata=%h want 0", mem_addr, mem_wstrb, mem_wdata);
    end
    m_rdata = 32'h0;
  endtask

  task automatic idle(input int n, input bit spur);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_sram_en = 1'b0;
      mem_gnt      = 1'b0;
      mem_rvalid   = spur;
      mem_bvalid   = spur;
      mem_rdata    = 32'h7777_0000 | 32'(i);
      #1;
      n_chk++;
      if (stallreq_mem !== 1'b0 || mem_req !== 1'b0 || data_sram_rdata !== m_rdata) begin
        n_err++;
        $display("FAIL idle got stall=%b req=%b rdata=%h want stall=0 req=0 rdata=%h", stallreq_mem, mem_req, data_sram_rdata, m_rdata);
      end
    end
    mem_rvalid = 1'b0;
    mem_bvalid = 1'b0;
  endtask

  // Drives one access with a responder that grants after gnt_wait REQ cycles and responds
  // resp_wait cycles after the grant (0 = same cycle); leaves en high through DONE.
  task automatic run_access(input string name, input logic [3:0] wen, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd, input int gnt_wait,
                            input int resp_wait, input bit no_resp, input bit spur);
    int          req_cnt  = 0;
    int          wait_cnt = 0;
    int          stall_cnt;
    int          cyc      = 0;
    int          exp_stall;
    bit          done     = 1'b0;
    bit          early    = 1'b0;
    logic [31:0] exp;
    @(negedge clk);
    data_sram_en    = 1'b1;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_bvalid = 1'b0;
    if (wen == 4'b0) m_rdata = no_resp ? 32'hDEAD_BEEF : rd;
    exp_q.push_back(m_rdata);
    #1;
    n_chk++;
    if (stallreq_mem !== 1'b1 || mem_req !== 1'b0) begin
      n_err++; $display("FAIL %s entry got stall=%b req=%b want stall=1 req=0", name, stallreq_mem, mem_req);
    end
    stall_cnt = 1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_bvalid = 1'b0;
      mem_rdata = $urandom;
      #1;
      if (mem_err !== 1'b0 && stallreq_mem === 1'b1) early = 1'b1;
      if (mem_req === 1'b1) begin
        n_chk++;
        if (mem_addr !== {addr[31:2], 2'b00} || mem_wstrb !== wen || mem_wr !== (wen != 4'b0) ||
            mem_wdata !== wd || stallreq_mem !== 1'b1) begin
          n_err++;
          $display("FAIL %s req_fields got addr=%h strb=%h wr=%b wdata=%h stall=%b want addr=%h strb=%h wr=%b wdata=%h stall=1",
                   name, mem_addr, mem_wstrb, mem_wr, mem_wdata, stallreq_mem, {addr[31:2], 2'b00}, wen, (wen != 4'b0), wd);
        end
        if (req_cnt == gnt_wait) begin
          mem_gnt = 1'b1;
          if (resp_wait == 0 && !no_resp) begin
            if (wen == 4'b0) begin mem_rvalid = 1'b1; mem_rdata = rd; end
            else mem_bvalid = 1'b1;
          end
        end
        req_cnt++;
        stall_cnt++;
      end else if (stallreq_mem === 1'b1) begin
        wait_cnt++;
        stall_cnt++;
        if (wait_cnt == resp_wait && !no_resp) begin
          if (wen == 4'b0) begin mem_rvalid = 1'b1; mem_rdata = rd; end
          else mem_bvalid = 1'b1;
        end else if (spur) begin
          if (wen == 4'b0) mem_bvalid = 1'b1;
          else mem_rvalid = 1'b1;
        end
      end else begin
        done = 1'b1;
      end
    end
    #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_bvalid = 1'b0;
    n_chk++;
    if (!done) begin
      n_err++; $display("FAIL %s completion got no DONE want DONE within 200 cycles", name);
      return;
    end
    exp = exp_q.pop_front();
    exp_stall = 1 + gnt_wait + 1 + (no_resp ? TMO : resp_wait);
    n_chk++;
    if (data_sram_rdata !== exp) begin
      n_err++; $display("FAIL %s rdata got=%h want=%h", name, data_sram_rdata, exp);
    end
    n_chk++;
    if (mem_err !== no_resp || early) begin
      n_err++; $display("FAIL %s mem_err got=%b early=%b want=%b early=0", name, mem_err, early, no_resp);
    end
    n_chk++;
    if (stall_cnt != exp_stall || req_cnt != gnt_wait + 1) begin
      n_err++; $display("FAIL %s latency got stall=%0d req=%0d want stall=%0d req=%0d", name, stall_cnt, req_cnt, exp_stall, gnt_wait + 1);
    end
  endtask

  task automatic test_read_zero_wait();
    run_access("read_zero_wait", 4'b0000, 32'h0000_1006, 32'h0, 32'h1234_5678, 0, 0, 1'b0, 1'b0);
    idle(2, 1'b0);
  endtask

  task automatic test_write_waits();
    run_access("write_waits", 4'b0011, 32'h0000_2000, 32'hAABB_CCDD, 32'h0, 3, 2, 1'b0, 1'b0);
    idle(1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_access("b2b_read", 4'b0000, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 1, 1, 1'b0, 1'b0);
    run_access("b2b_write", 4'b1111, 32'h0000_3004, 32'h0102_0304, 32'h0, 0, 0, 1'b0, 1'b0);
    run_access("b2b_read2", 4'b0000, 32'h0000_3009, 32'h0, 32'h0BAD_C0DE, 0, 2, 1'b0, 1'b0);
    idle(1, 1'b0);
  endtask

  task automatic test_timeout();
    run_access("timeout_read", 4'b0000, 32'h0000_4000, 32'h0, 32'h0, 0, 0, 1'b1, 1'b0);
    idle(1, 1'b0);
    run_access("timeout_write", 4'b1000, 32'h0000_4010, 32'h5A00_0000, 32'h0, 2, 0, 1'b1, 1'b0);
    idle(1, 1'b0);
  endtask

  task automatic test_spurious();
    idle(3, 1'b1);
    run_access("spur_read", 4'b0000, 32'h0000_5000, 32'h0, 32'h600D_DA7A, 1, 3, 1'b0, 1'b1);
    run_access("spur_write", 4'b0100, 32'h0000_5004, 32'h00EE_0000, 32'h0, 0, 2, 1'b0, 1'b1);
    idle(1, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h0000_0040;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    n_chk++;
    if (mem_req !== 1'b0 || stallreq_mem !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_inwait got req=%b stall=%b want req=0 stall=1", mem_req, stallreq_mem);
    end
    resetn = 1'b0;
    #1;
    n_chk++;
    if (mem_req !== 1'b0 || stallreq_mem !== 1'b0 || data_sram_rdata !== 32'h0) begin
      n_err++; $display("FAIL reset_mid_async got req=%b stall=%b rdata=%h want 0 0 00000000", mem_req, stallreq_mem, data_sram_rdata);
    end
    m_rdata = 32'h0;
    exp_q.push_back(32'h0);
    @(negedge clk);
    data_sram_en = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h5555_5555;
      #1;
      n_chk++;
      if (mem_req !== 1'b0 || stallreq_mem !== 1'b0) begin
        n_err++; $display("FAIL reset_mid_late got req=%b stall=%b want 0 0", mem_req, stallreq_mem);
      end
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    n_chk++;
    if (data_sram_rdata !== exp_q.pop_front()) begin
      n_err++; $display("FAIL reset_mid_rdata got=%h want=00000000", data_sram_rdata);
    end
    run_access("post_reset_read", 4'b0000, 32'h0000_6000, 32'h0, 32'h1357_9BDF, 0, 0, 1'b0, 1'b0);
    idle(1, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    data_sram_en = 1'b0; data_sram_wen = 4'b0; data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_bvalid = 1'b0;
    m_rdata = 32'h0;
    test_reset();
    @(negedge clk);
    resetn = 1'b1;
    test_read_zero_wait();
    test_write_waits();
    test_back_to_back();
    test_timeout();
    test_spurious();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
